// File: rtl/cic_pkg.sv
// cic_pkg: shared CIC sizing helpers for decimator and interpolator
package cic_pkg;
  function automatic int cic_growth_bits(input int r, input int m, input int n, input bit interp);
    longint g;
    g = 1;
    for (int k = 0; k < n; k++) g = g * longint'(r * m);
    if (interp) g = g / longint'(r);
    return interp ? $clog2(g) + n : $clog2(g);
  endfunction
endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage: one registered comb y <= x - x(M accepts ago), advancing on en_i
module cic_comb_stage #(
  parameter int W = 20,
  parameter int M = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic signed [W-1:0] x_i,
  output logic signed [W-1:0] y_o
);
  logic signed [W-1:0] dly_q [M];
  logic signed [W-1:0] y_q, y_d;
  assign y_d = x_i - dly_q[M-1];
  assign y_o = y_q;
  // difference register and M-deep delay line both advance only on an accepted input
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      y_q   <= '0;
      dly_q <= '{default: '0};
    end else if (en_i) begin
      y_q      <= y_d;
      dly_q[0] <= x_i;
      for (int k = 1; k < M; k++) dly_q[k] <= dly_q[k-1];
    end
endmodule

// File: rtl/cic_interpolator.sv
// cic_interpolator: N-stage CIC interpolator by R with valid/ready on both sides
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int InputLengthBits     = 12,
  parameter int InterpolationFactor = 5,
  parameter int DelayLength         = 1,
  parameter int FilterOrder         = 3,
  parameter int InternalLengthBits  = 20,
  parameter int OutputLengthBits    = 24
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic signed [InputLengthBits-1:0]  in,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic signed [OutputLengthBits-1:0] out,
  output logic                               out_valid,
  input  logic                               out_ready
);
  localparam int IW = InternalLengthBits;
  localparam int N  = FilterOrder;
  localparam int PW = $clog2(InterpolationFactor);

  if (InterpolationFactor < 2 || (DelayLength != 1 && DelayLength != 2)) begin : g_bad_param
    $error("cic_interpolator: R must be >= 2 and M must be 1 or 2");
  end
  if (IW < InputLengthBits + cic_growth_bits(InterpolationFactor, DelayLength, N, 1'b1)) begin : g_bad_width
    $error("cic_interpolator: InternalLengthBits too small for bit growth");
  end
  if (OutputLengthBits < IW) begin : g_bad_out
    $error("cic_interpolator: OutputLengthBits must be >= InternalLengthBits");
  end

  logic [PW-1:0]       p_q, p_d;
  logic                out_valid_q, out_valid_d, step, accept;
  logic signed [IW-1:0] c [N+1];
  logic signed [IW-1:0] i_q [N];
  logic signed [IW-1:0] i_d [N];
  logic signed [IW-1:0] u;

  assign c[0]      = IW'(in);
  assign in_ready  = rst && p_q == '0 && (!out_valid_q || out_ready);
  assign out_valid = out_valid_q;
  assign out       = OutputLengthBits'(i_q[N-1]);

  for (genvar k = 0; k < N; k++) begin : g_comb
    cic_comb_stage #(.W(IW), .M(DelayLength)) u_comb (
      .clk  (clk),
      .rst  (rst),
      .en_i (accept),
      .x_i  (c[k]),
      .y_o  (c[k+1])
    );
  end

  // step/accept decode, phase advance, zero-stuffing upsampler and integrator next state
  always_comb begin
    step        = (!out_valid_q || out_ready) && (p_q != '0 || in_valid);
    accept      = step && p_q == '0;
    p_d         = p_q == PW'(InterpolationFactor - 1) ? '0 : p_q + PW'(1);
    out_valid_d = step ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    u           = p_q == '0 ? c[N] : '0;
    i_d[0]      = i_q[0] + u;
    for (int k = 1; k < N; k++) i_d[k] = i_q[k] + i_q[k-1];
  end

  // output-rate state: integrators and phase move on step, out_valid tracks the handshake
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      p_q         <= '0;
      out_valid_q <= 1'b0;
      i_q         <= '{default: '0};
    end else begin
      out_valid_q <= out_valid_d;
      if (step) begin
        p_q <= p_d;
        i_q <= i_d;
      end
    end
endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: directed checks of the CIC interpolator against its impulse response
module tb_cic_interpolator;
  logic               clk = 1'b0;
  logic               rst;
  logic signed [11:0] din;
  logic               in_valid, in_ready, out_valid, out_ready;
  logic signed [23:0] dout;

  int checks = 0;
  int errors = 0;
  int xs[$];
  int xa[$];
  int outs[$];
  int last_val, last_ovh;
  int h[13] = '{1, 3, 6, 10, 15, 18, 19, 18, 15, 10, 6, 3, 1};

  cic_interpolator dut (
    .clk       (clk),
    .rst       (rst),
    .in        (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (dout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model(input int j);
    int s = 0;
    for (int n = 0; n < xa.size(); n++) begin
      int k = j - 17 - 5 * n;
      if (k >= 0 && k <= 12) s += xa[n] * h[k];
    end
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    din = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run(input string tag, input int rdy_pct, input int gap, input bit record, input bit cmp_rec, input bit chk_rdy);
    int idx = 0, j = 0, cyc = 0, ovh = 0, held = 0;
    int n_out = 5 * xs.size();
    bit stalled = 0, pend = 0;
    xa.delete();
    if (record) outs.delete();
    do_reset();
    while (j < n_out && cyc < 20000) begin
      @(negedge clk);
      if (gap == 0 || cyc % gap == 0) pend = 1;
      out_ready = $urandom_range(99) < rdy_pct;
      in_valid  = pend && idx < xs.size();
      din       = idx < xs.size() ? 12'(xs[idx]) : '0;
      #1;
      if (stalled) check({tag, "_hold"}, int'(dout), held);
      if (chk_rdy && idx < xs.size()) check({tag, "_in_ready"}, int'(in_ready), int'(cyc % 5 == 0));
      ovh += int'(out_valid);
      if (out_valid && out_ready) begin
        check(tag, int'(dout), model(j));
        if (record) outs.push_back(int'(dout));
        if (cmp_rec) check({tag, "_vs_ref"}, int'(dout), outs[j]);
        last_val = int'(dout);
        j++;
      end
      stalled = out_valid && !out_ready;
      held = int'(dout);
      if (in_valid && in_ready) begin
        xa.push_back(xs[idx]);
        idx++;
        pend = 0;
      end
      cyc++;
    end
    check({tag, "_outputs"}, j, n_out);
    last_ovh = ovh;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    din = '0;
    #2;
    rst = 1'b0;
    din = 12'hAAA;
    in_valid = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      #1;
      check("rst_out", int'(dout), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready", int'(in_ready), 0);
    end
    xs.delete();
    repeat (200) xs.push_back(0);
    run("zero", 100, 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b1;
    din = 12'sd777;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    xs = '{1, 0, 0, 0, 0, 0, 0, 0};
    run("impulse", 100, 0, 0, 0, 0);
    check("impulse_tail", last_val, 0);
    xs.delete();
    repeat (12) xs.push_back(1);
    run("dc_pos", 100, 0, 0, 0, 0);
    check("dc_pos_final", last_val, 25);
    xs.delete();
    repeat (12) xs.push_back(-2048);
    run("dc_neg", 100, 0, 0, 0, 0);
    check("dc_neg_final", last_val, -51200);
    xs.delete();
    repeat (30) xs.push_back(int'($urandom_range(4095)) - 2048);
    run("bp_ref", 100, 0, 1, 0, 0);
    run("bp", 50, 0, 0, 1, 0);
    xs.delete();
    repeat (10) xs.push_back(int'($urandom_range(4095)) - 2048);
    run("gap", 100, 20, 0, 0, 0);
    check("gap_valid_cycles", last_ovh, 50);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cic_interpolator.md
# cic_interpolator

Cascaded integrator-comb (CIC) interpolator: accepts signed samples at a low rate and emits InterpolationFactor signed output samples per input. It is the transmit-side counterpart of the CIC decimator and sits between a baseband sample source and a high-rate DAC/mixer path. Flow control is valid/ready on both sides, so the block can be driven by sparse inputs and stalled by a slow consumer.

## Interface
- InputLengthBits, 12, signed input width
- InterpolationFactor, 5, R: output samples per input sample (≥2)
- DelayLength, 1, M: differential delay of each comb (1 or 2)
- FilterOrder, 3, N: number of comb stages and number of integrator stages
- InternalLengthBits, 20, width of all comb and integrator registers; must be ≥ InputLengthBits + ceil(log2((R·M)^N / R)) + N
- OutputLengthBits, 24, output width; must be ≥ InternalLengthBits
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- in  in  InputLengthBits  signed input sample
- in_valid  in  1  input sample present
- in_ready  out  1  block accepts input this cycle
- out  out  OutputLengthBits  signed output sample
- out_valid  out  1  out holds an unconsumed sample
- out_ready  in  1  consumer accepts out this cycle

## Operation
- Phase counter p ∈ [0, R-1], reset 0.
- step = (!out_valid || out_ready) && (p != 0 || in_valid). All state advances only on step.
- in_ready = (p == 0) && (!out_valid || out_ready), forced 0 while rst is low. An input is accepted iff step && p == 0.
- On step: p ← (p == R-1) ? 0 : p+1.
- Comb section (input rate, advances only on input accept): c_0 = in sign-extended to InternalLengthBits; c_k ← c_{k-1} − c_{k-1} delayed M accepts, k = 1..N; each stage registered.
- Upsampler: u = c_N register value before this step's update when p == 0, else 0.
- Integrator section (output rate, advances every step): i_1 ← i_1 + u; i_k ← i_k + i_{k-1} (pre-update), k = 2..N.
- out = i_N sign-extended to OutputLengthBits.
- All arithmetic two's complement, wrap modulo 2^InternalLengthBits; no saturation. Wrap in integrators is intentional and correct given the width rule.
- DC gain (R·M)^N / R; impulse response = N-fold convolution of a length-R·M boxcar.

## Timing
- Reset (rst low, asynchronous): all comb/delay/integrator registers 0, p = 0, out = 0, out_valid = 0, in_ready = 0. Reset mid-burst discards the partial burst; the first input after release is accepted at phase 0.
- out_valid ← 1 on step; ← 0 when out_ready && !step; otherwise held. out is stable while out_valid && !out_ready.
- Throughput: one output per cycle when out_ready is high and inputs arrive at least every R cycles; input accepted at most once per R steps.
- Latency, counted in output handshakes since reset: an input accepted as sample n first affects output index n·R + N·R + N − 1 (17 with defaults).
- Simultaneous in_valid with p != 0: input not accepted, in_ready low, in must be held by the source.
- out_ready low with out_valid high: no step, p frozen, in_ready low; no sample lost or duplicated.

## Structure
- Shared package cic_pkg: constant function cic_growth_bits(R, M, N, interp) returning the required internal growth; used in elaboration-time assertions for both decimator and interpolator.
- Sub-module cic_comb_stage (one registered comb with M-deep delay line and enable), instantiated N times via generate; integrators inline.

## Test plan
- Hold rst low 1000 cycles with in = 12'hAAA, in_valid = 1, out_ready = 1 -> out = 0, out_valid = 0, in_ready = 0 throughout.
- in = 0, in_valid = 1, out_ready = 1 for 1000 cycles -> out = 0 every cycle; in_ready high exactly 1 cycle in every 5.
- Impulse: in = 1 once then zeros, out_ready = 1 -> output indices 0..16 are 0, 17..29 are 1,3,6,10,15,18,19,18,15,10,6,3,1, then 0.
- DC: in = 1 continuously -> output settles to 25; in = −2048 continuously -> settles to −51200 with no wrap visible on out.
- Backpressure: random out_ready (50%) with random input stream -> output sequence identical to the out_ready = 1 run; out stable while out_valid && !out_ready.
- in_valid gaps: one input every 20 cycles, out_ready = 1 -> exactly 5 out_valid pulses per input, out_valid low otherwise, no sample dropped.
